// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - core-side and RAM-side signal bundle for mem_ctrl
interface mem_ctrl_if;
  logic        if_enable_i;
  logic [31:0] if_addr_i;
  logic        if_finished_o;
  logic [31:0] if_data_o;
  logic        mem_enable_i;
  logic [31:0] mem_addr_i;
  logic [2:0]  mem_data_len_i;
  logic [31:0] mem_data_i;
  logic        mem_rw_sel_i;
  logic        mem_finished_o;
  logic [31:0] mem_data_o;
  logic        if_busy_o;
  logic        mem_busy_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic        io_buffer_full_i;

  modport master (
    output if_enable_i, if_addr_i, mem_enable_i, mem_addr_i, mem_data_len_i,
           mem_data_i, mem_rw_sel_i, ram_din_i, io_buffer_full_i,
    input  if_finished_o, if_data_o, mem_finished_o, mem_data_o, if_busy_o,
           mem_busy_o, ram_dout_o, ram_a_o, ram_wr_o
  );

  modport slave (
    input  if_enable_i, if_addr_i, mem_enable_i, mem_addr_i, mem_data_len_i,
           mem_data_i, mem_rw_sel_i, ram_din_i, io_buffer_full_i,
    output if_finished_o, if_data_o, mem_finished_o, mem_data_o, if_busy_o,
           mem_busy_o, ram_dout_o, ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial IF/MEM memory controller for the 8-bit RAM/IO bus
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  s_q, s_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        serve_mem_q, serve_mem_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        if_fin_q, if_fin_d;
  logic        mem_fin_q, mem_fin_d;
  logic        if_busy_q, if_busy_d;
  logic        mem_busy_q, mem_busy_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;

  logic [2:0]  mem_len;
  logic        mem_go;
  logic        io_stall_req;
  logic        io_stall_cur;
  logic [1:0]  rd_idx;
  logic [1:0]  last_idx;
  logic [31:0] rd_final;

  assign mem_len      = (bus.mem_data_len_i > 3'd4) ? 3'd4 : bus.mem_data_len_i;
  assign mem_go       = bus.mem_enable_i && (mem_len != 3'd0);
  assign io_stall_req = bus.mem_rw_sel_i && (bus.mem_addr_i[17:16] == IO_ADDR_HI) && bus.io_buffer_full_i;
  assign io_stall_cur = (base_q[17:16] == IO_ADDR_HI) && bus.io_buffer_full_i;
  // RAM is one cycle behind the address: byte s-2 arrives at step s, the last one at step len+1.
  assign rd_idx   = s_q[1:0] - 2'd2;
  assign last_idx = len_q[1:0] - 2'd1;

  always_comb begin
    rd_final = rbuf_q;
    rd_final[{last_idx, 3'b000} +: 8] = bus.ram_din_i;
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    serve_mem_d = serve_mem_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    if_fin_d    = 1'b0;
    mem_fin_d   = 1'b0;
    if_busy_d   = if_busy_q;
    mem_busy_d  = mem_busy_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_go) begin
          serve_mem_d = 1'b1;
          base_d      = bus.mem_addr_i;
          len_d       = mem_len;
          wdata_d     = bus.mem_data_i;
          rbuf_d      = 32'd0;
          if_busy_d   = 1'b1;
          ram_a_d     = bus.mem_addr_i;
          if (bus.mem_rw_sel_i) begin
            state_d = ST_WR;
            // A full IO FIFO defers byte 0 into WR with s = 0.
            if (io_stall_req) begin
              s_d      = 3'd0;
              ram_wr_d = 1'b0;
            end else begin
              s_d        = 3'd1;
              ram_wr_d   = 1'b1;
              ram_dout_d = bus.mem_data_i[7:0];
            end
          end else begin
            state_d  = ST_RD;
            s_d      = 3'd1;
            ram_wr_d = 1'b0;
          end
        end else if (bus.if_enable_i) begin
          serve_mem_d = 1'b0;
          base_d      = bus.if_addr_i;
          len_d       = 3'd4;
          rbuf_d      = 32'd0;
          mem_busy_d  = 1'b1;
          ram_a_d     = bus.if_addr_i;
          ram_wr_d    = 1'b0;
          s_d         = 3'd1;
          state_d     = ST_RD;
        end
      end
      ST_RD: begin
        if (s_q == len_q + 3'd1) begin
          if (serve_mem_q) begin
            mem_data_d = rd_final;
            mem_fin_d  = 1'b1;
          end else begin
            if_data_d = rd_final;
            if_fin_d  = 1'b1;
          end
          ram_a_d = 32'd0;
          state_d = ST_DONE;
        end else begin
          if (s_q < len_q) ram_a_d = base_q + {29'd0, s_q};
          if (s_q >= 3'd2) rbuf_d[{rd_idx, 3'b000} +: 8] = bus.ram_din_i;
          s_d = s_q + 3'd1;
        end
      end
      ST_WR: begin
        if (s_q == len_q) begin
          ram_wr_d  = 1'b0;
          mem_fin_d = 1'b1;
          ram_a_d   = 32'd0;
          state_d   = ST_DONE;
        end else if (io_stall_cur) begin
          ram_wr_d = 1'b0;
        end else begin
          ram_a_d    = base_q + {29'd0, s_q};
          ram_dout_d = wdata_q[{s_q[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
          s_d        = s_q + 3'd1;
        end
      end
      ST_DONE: begin
        if_busy_d  = 1'b0;
        mem_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      serve_mem_q <= 1'b0;
      rbuf_q      <= 32'd0;
      if_data_q   <= 32'd0;
      mem_data_q  <= 32'd0;
      if_fin_q    <= 1'b0;
      mem_fin_q   <= 1'b0;
      if_busy_q   <= 1'b0;
      mem_busy_q  <= 1'b0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      s_q         <= s_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      serve_mem_q <= serve_mem_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      if_fin_q    <= if_fin_d;
      mem_fin_q   <= mem_fin_d;
      if_busy_q   <= if_busy_d;
      mem_busy_q  <= mem_busy_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign bus.if_finished_o  = if_fin_q;
  assign bus.if_data_o      = if_data_q;
  assign bus.mem_finished_o = mem_fin_q;
  assign bus.mem_data_o     = mem_data_q;
  assign bus.if_busy_o      = if_busy_q;
  assign bus.mem_busy_o     = mem_busy_q;
  assign bus.ram_a_o        = ram_a_q;
  assign bus.ram_dout_o     = ram_dout_q;
  assign bus.ram_wr_o       = ram_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  mem_ctrl_if bus ();

  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ram [0:8191];
  logic [7:0] io_q [$];

  // Synchronous RAM: frozen with rdy like the rest of the system.
  always @(posedge clk) begin
    if (bus.ram_wr_o) begin
      if (bus.ram_a_o[17:16] == 2'b11) io_q.push_back(bus.ram_dout_o);
      else ram[bus.ram_a_o[12:0]] <= bus.ram_dout_o;
    end
    if (rdy) bus.ram_din_i <= ram[bus.ram_a_o[12:0]];
    if (rst) begin
      ram[13'h1000] <= 8'h78; ram[13'h1001] <= 8'h56;
      ram[13'h1002] <= 8'h34; ram[13'h1003] <= 8'h12;
      ram[13'h0102] <= 8'h11; ram[13'h0103] <= 8'h22;
      ram[13'h0303] <= 8'h99;
      ram[13'h0040] <= 8'h21; ram[13'h0041] <= 8'h43;
    end
  end

  typedef struct {
    bit          is_if;
    bit          rw;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    bit          port_mem;
    bit          chk_data;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q [$];
  vec_t vecs [13];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.if_finished_o || bus.mem_finished_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_finish", {30'd0, bus.if_finished_o, bus.mem_finished_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("finish_port", {30'd0, bus.if_finished_o, bus.mem_finished_o}, e.port_mem ? 32'd1 : 32'd2);
        chk("finish_cycle", 32'(cyc), 32'(e.due));
        if (e.chk_data) chk("read_data", e.port_mem ? bus.mem_data_o : bus.if_data_o, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_fin(input bit port_mem, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (port_mem ? bus.mem_finished_o : bus.if_finished_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("finish_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic push_exp(input bit port_mem, input bit chk_data, input logic [31:0] data, input int due);
    exp_t e;
    e.port_mem = port_mem;
    e.chk_data = chk_data;
    e.data     = data;
    e.due      = due;
    exp_q.push_back(e);
  endtask

  task automatic drive_mem(input bit rw, input logic [31:0] addr, input logic [2:0] len, input logic [31:0] wdata);
    bus.mem_enable_i   = 1'b1;
    bus.mem_rw_sel_i   = rw;
    bus.mem_addr_i     = addr;
    bus.mem_data_len_i = len;
    bus.mem_data_i     = wdata;
  endtask

  task automatic run_txn(input vec_t v);
    if (v.is_if) begin
      bus.if_enable_i = 1'b1;
      bus.if_addr_i   = v.addr;
    end else begin
      drive_mem(v.rw, v.addr, v.len, v.wdata);
    end
    push_exp(!v.is_if, !v.rw, v.exp, cyc + 1 + v.lat);
    wait_fin(!v.is_if, 20);
    bus.if_enable_i  = 1'b0;
    bus.mem_enable_i = 1'b0;
    tick();
  endtask

  int t0;
  int nfin;
  logic [7:0] b;
  vec_t fetch;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_1000, 3'd4, 32'h0,          32'h1234_5678, 5};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0020, 3'd1, 32'h0000_00AB,  32'h0,         1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0020, 3'd1, 32'h0,          32'h0000_00AB, 2};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF,  32'h0,         2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0100, 3'd4, 32'h0,          32'h2211_BEEF, 5};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,          32'h0000_BEEF, 3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_1000, 3'd3, 32'h0,          32'h0034_5678, 4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_1000, 3'd7, 32'h0,          32'h1234_5678, 5};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_1000, 3'd0, 32'h0,          32'h1234_5678, 5};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0200, 3'd4, 32'hCAFE_F00D,  32'h0,         4};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0200, 3'd4, 32'h0,          32'hCAFE_F00D, 5};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0300, 3'd3, 32'h77A1_B2C3,  32'h0,         3};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0300, 3'd4, 32'h0,          32'h99A1_B2C3, 5};

    rst = 1'b1;
    rdy = 1'b1;
    bus.if_enable_i      = 1'b0;
    bus.if_addr_i        = 32'd0;
    bus.mem_enable_i     = 1'b0;
    bus.mem_addr_i       = 32'd0;
    bus.mem_data_len_i   = 3'd0;
    bus.mem_data_i       = 32'd0;
    bus.mem_rw_sel_i     = 1'b0;
    bus.io_buffer_full_i = 1'b0;
    repeat (3) tick();
    chk("rst_if_finished",  {31'd0, bus.if_finished_o}, 32'd0);
    chk("rst_mem_finished", {31'd0, bus.mem_finished_o}, 32'd0);
    chk("rst_if_data",      bus.if_data_o, 32'd0);
    chk("rst_mem_data",     bus.mem_data_o, 32'd0);
    chk("rst_ram_a",        bus.ram_a_o, 32'd0);
    chk("rst_ram_wr_dout",  {23'd0, bus.ram_wr_o, bus.ram_dout_o}, 32'd0);
    chk("rst_busy",         {30'd0, bus.if_busy_o, bus.mem_busy_o}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);
    chk("ram_sb_byte",   {24'd0, ram[13'h0020]}, 32'h0000_00AB);
    chk("ram_sh_keep",   {24'd0, ram[13'h0102]}, 32'h0000_0011);
    chk("ram_s3_keep",   {24'd0, ram[13'h0303]}, 32'h0000_0099);

    // Length 0 must not start anything.
    drive_mem(1'b0, 32'h1000, 3'd0, 32'h0);
    nfin = 0;
    repeat (6) begin
      tick();
      if (bus.mem_finished_o) nfin++;
    end
    chk("len0_no_finish", 32'(nfin), 32'd0);
    chk("len0_no_busy", {30'd0, bus.if_busy_o, bus.mem_busy_o}, 32'd0);
    bus.mem_enable_i = 1'b0;
    tick();

    // Simultaneous IF + MEM (LH 0x40): MEM first, IF starts on the next IDLE.
    bus.if_enable_i = 1'b1;
    bus.if_addr_i   = 32'h1000;
    drive_mem(1'b0, 32'h40, 3'd2, 32'h0);
    t0 = cyc + 1;
    push_exp(1'b1, 1'b1, 32'h0000_4321, t0 + 3);
    push_exp(1'b0, 1'b1, 32'h1234_5678, t0 + 10);
    tick();
    chk("arb_if_busy", {30'd0, bus.if_busy_o, bus.mem_busy_o}, 32'd2);
    wait_fin(1'b1, 10);
    bus.mem_enable_i = 1'b0;
    repeat (3) tick();
    chk("arb_mem_busy", {30'd0, bus.if_busy_o, bus.mem_busy_o}, 32'd1);
    wait_fin(1'b0, 12);
    bus.if_enable_i = 1'b0;
    tick();

    // IO write with FIFO full for three edges.
    io_q.delete();
    bus.io_buffer_full_i = 1'b1;
    drive_mem(1'b1, 32'h0003_0000, 3'd4, 32'h4433_2211);
    t0 = cyc + 1;
    push_exp(1'b1, 1'b0, 32'h0, t0 + 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("io_stall_no_wr", {31'd0, bus.ram_wr_o}, 32'd0);
    end
    bus.io_buffer_full_i = 1'b0;
    wait_fin(1'b1, 12);
    bus.mem_enable_i = 1'b0;
    tick();
    chk("io_write_count", 32'(io_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      b = (io_q.size() != 0) ? io_q.pop_front() : 8'hxx;
      chk("io_write_byte", {24'd0, b}, 32'(8'h11 * (i + 1)));
    end

    // rdy low for two edges in the middle of a LW.
    drive_mem(1'b0, 32'h1000, 3'd4, 32'h0);
    t0 = cyc + 1;
    push_exp(1'b1, 1'b1, 32'h1234_5678, t0 + 7);
    repeat (3) tick();
    rdy = 1'b0;
    repeat (2) tick();
    rdy = 1'b1;
    wait_fin(1'b1, 10);
    bus.mem_enable_i = 1'b0;
    tick();

    // rdy low gates an in-flight store byte.
    drive_mem(1'b1, 32'h50, 3'd1, 32'h0000_005A);
    t0 = cyc + 1;
    push_exp(1'b1, 1'b0, 32'h0, t0 + 2);
    tick();
    chk("sb_wr_high", {31'd0, bus.ram_wr_o}, 32'd1);
    chk("sb_addr_dout", {bus.ram_a_o[23:0], bus.ram_dout_o}, 32'h0000_505A);
    rdy = 1'b0;
    #1;
    chk("rdy_low_wr_forced", {31'd0, bus.ram_wr_o}, 32'd0);
    tick();
    chk("rdy_low_wr_held", {31'd0, bus.ram_wr_o}, 32'd0);
    rdy = 1'b1;
    #1;
    chk("rdy_back_wr", {31'd0, bus.ram_wr_o}, 32'd1);
    wait_fin(1'b1, 6);
    bus.mem_enable_i = 1'b0;
    tick();
    chk("ram_sb_rdy", {24'd0, ram[13'h0050]}, 32'h0000_005A);

    // Reset two edges into an IF fetch aborts it.
    bus.if_enable_i = 1'b1;
    bus.if_addr_i   = 32'h1000;
    repeat (2) tick();
    rst = 1'b1;
    bus.if_enable_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_if_data", bus.if_data_o, 32'd0);
    chk("abort_ram_a", bus.ram_a_o, 32'd0);
    chk("abort_flags", {27'd0, bus.ram_wr_o, bus.if_finished_o, bus.mem_finished_o, bus.if_busy_o, bus.mem_busy_o}, 32'd0);
    nfin = 0;
    repeat (8) begin
      tick();
      if (bus.if_finished_o) nfin++;
    end
    chk("abort_no_finish", 32'(nfin), 32'd0);
    fetch = '{1'b1, 1'b0, 32'h0000_1000, 3'd0, 32'h0, 32'h1234_5678, 5};
    run_txn(fetch);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
